// File: rtl/bram_fetch_engine_if.sv
// Control, BRAM read-port and downstream stream bundle for bram_fetch_engine.
// The slave modport is the engine; the master modport is whoever drives it.
interface bram_fetch_engine_if #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 11,
  parameter int LEN_W   = 11,
  parameter int NUM_BUF = 2
);
  localparam int SEL_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

  logic              start_fetch;
  logic [LEN_W-1:0]  fetch_len;
  logic [SEL_W-1:0]  buf_sel;
  logic              reset_addr_counter;
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              fetch_done;

  modport master (
    output start_fetch, fetch_len, buf_sel, reset_addr_counter, bram_dout, m_ready,
    input  bram_en, bram_addr, m_valid, m_data, m_last, busy, fetch_done
  );

  modport slave (
    input  start_fetch, fetch_len, buf_sel, reset_addr_counter, bram_dout, m_ready,
    output bram_en, bram_addr, m_valid, m_data, m_last, busy, fetch_done
  );
endinterface

// File: rtl/bram_fetch_engine.sv
// Streams fetch_len words out of one BRAM region, with a persistent wrapping
// read offset and a small credit-checked skid FIFO behind the read latency.
module bram_fetch_engine #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 11,
  parameter int NUM_BUF   = 2,
  parameter int BUF_DEPTH = 1024,
  parameter int RD_LAT    = 1,
  parameter int LEN_W     = 11
) (
  input logic               clk,
  input logic               rst,
  bram_fetch_engine_if.slave bus
);
  localparam int SEL_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int OFF_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int DEPTH = RD_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(2 * DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e            state_q;
  logic [OFF_W-1:0]  off_q;
  logic [SEL_W-1:0]  sel_q;
  logic [LEN_W-1:0]  rem_q;
  logic              en_q, last_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q;

  logic [RD_LAT:1]   vld_pipe_q, lst_pipe_q;
  logic [RD_LAT:0]   vld_pipe, lst_pipe;
  ent_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q, inflight;
  logic              push, pop, m_valid_w, can_issue;
  ent_t              head, push_ent;
  logic [ADDR_W-1:0] base, rd_addr;
  logic [OFF_W-1:0]  off_nx;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Bit 0 is the read being presented this cycle; bit RD_LAT has data on bram_dout.
  assign vld_pipe = {vld_pipe_q, en_q};
  assign lst_pipe = {lst_pipe_q, last_q};
  assign push     = vld_pipe[RD_LAT];
  assign push_ent = '{last: lst_pipe[RD_LAT], data: bus.bram_dout};
  assign head     = mem_q[rd_ptr_q];
  assign m_valid_w = (cnt_q != '0);
  assign pop      = m_valid_w & bus.m_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
  end

  // A word popped this cycle frees its slot before the new read can land.
  assign can_issue = (rem_q != '0) &&
                     ((cnt_q + inflight) < (CNT_W'(DEPTH) + CNT_W'(pop)));

  assign base    = ADDR_W'(sel_q) * ADDR_W'(BUF_DEPTH);
  assign rd_addr = base + ADDR_W'(off_q);
  assign off_nx  = (off_q == OFF_W'(BUF_DEPTH - 1)) ? '0 : off_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      sel_q   <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.reset_addr_counter) off_q <= '0;
          if (bus.start_fetch) begin
            if (bus.fetch_len != '0) begin
              state_q <= ISSUE;
              busy_q  <= 1'b1;
              sel_q   <= (NUM_BUF == 1) ? '0 : bus.buf_sel;
              rem_q   <= bus.fetch_len;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (can_issue) begin
            en_q   <= 1'b1;
            addr_q <= rd_addr;
            last_q <= (rem_q == LEN_W'(1));
            off_q  <= off_nx;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe[RD_LAT-1:0];
      lst_pipe_q <= lst_pipe[RD_LAT-1:0];
      if (push) wr_ptr_q <= nxt(wr_ptr_q);
      if (pop)  rd_ptr_q <= nxt(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

  assign bus.bram_en    = en_q;
  assign bus.bram_addr  = addr_q;
  assign bus.m_valid    = m_valid_w;
  assign bus.m_data     = m_valid_w ? head.data : '0;
  assign bus.m_last     = m_valid_w & head.last;
  assign bus.busy       = busy_q;
  assign bus.fetch_done = done_q;
endmodule

// File: doc/bram_fetch_engine.md
BRAM_FETCH_ENGINE -- requirements
Module: bram_fetch_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 256, BRAM read-port / stream data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, BRAM read-port address width.
REQ-003 SHALL have parameter NUM_BUF, default 2, number of buffer regions (power of 2, 1..8).
REQ-004 SHALL have parameter BUF_DEPTH, default 1024, words per region; NUM_BUF*BUF_DEPTH <= 2**ADDR_W.
REQ-005 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (1 or 2).
REQ-006 SHALL have parameter LEN_W, default 11, width of fetch_len.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port start_fetch  input  1  single-cycle fetch request.
REQ-010 SHALL have port fetch_len  input  LEN_W  words to fetch, sampled with start_fetch.
REQ-011 SHALL have port buf_sel  input  max(1,log2(NUM_BUF))  region select, sampled with start_fetch.
REQ-012 SHALL have port reset_addr_counter  input  1  clear read offset.
REQ-013 SHALL have port bram_en  output  1  BRAM port-B read enable.
REQ-014 SHALL have port bram_addr  output  ADDR_W  BRAM port-B address.
REQ-015 SHALL have port bram_dout  input  DATA_W  BRAM read data, valid RD_LAT cycles after bram_en.
REQ-016 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_W, m_last output 1  downstream stream.
REQ-017 SHALL have ports busy output 1 and fetch_done output 1 (one-cycle pulse).

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start_fetch with fetch_len>0; ISSUE->DRAIN after last read issued; DRAIN->IDLE when last word accepted (m_valid&m_ready&m_last).
REQ-019 SHALL ignore start_fetch when busy=1; busy=1 in ISSUE and DRAIN only.
REQ-020 SHALL, on start_fetch with fetch_len=0 in IDLE, stay IDLE, issue no reads, and pulse fetch_done the next cycle.
REQ-021 SHALL form bram_addr = buf_sel_latched*BUF_DEPTH + offset, offset in [0, BUF_DEPTH-1].
REQ-022 SHALL increment offset by 1 per issued read, wrapping BUF_DEPTH-1 -> 0 without error.
REQ-023 SHALL retain offset across fetches so consecutive fetches read contiguous words.
REQ-024 SHALL clear offset on reset_addr_counter in IDLE; SHALL ignore it while busy; if coincident with start_fetch, first word read SHALL come from offset 0.
REQ-025 SHALL buffer returning data in an internal FIFO of depth RD_LAT+2, issuing a read only when occupancy plus in-flight reads < RD_LAT+2.
REQ-026 SHALL sustain one word per cycle when m_ready is held 1 (no bubbles after first word).
REQ-027 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-028 SHALL assert m_last with exactly the fetch_len-th word of a fetch.
REQ-029 SHALL pulse fetch_done the cycle after the last word is accepted, concurrent with busy falling.
REQ-030 SHALL accept a new start_fetch in the cycle fetch_done is high.
REQ-031 SHALL present the first word on m_valid no earlier than RD_LAT+1 cycles after start_fetch.

Reset
REQ-032 SHALL, on rst=1, immediately force state IDLE, offset 0, FIFO empty, in-flight reads discarded.
REQ-033 SHALL drive bram_en=0, bram_addr=0, m_valid=0, m_last=0, m_data=0, busy=0, fetch_done=0 during reset.
REQ-034 SHALL, after rst mid-fetch, emit no stale data and begin the next fetch at offset 0.

Verification
REQ-035 Preload BRAM addr n with n+1; start_fetch len=4 buf_sel=0, m_ready=1 -> data 1,2,3,4 on consecutive cycles, m_last on 4, fetch_done next cycle.
REQ-036 Repeat len=4 twice without reset_addr_counter -> second fetch yields 5..8; then reset_addr_counter + len=2 -> 1,2.
REQ-037 buf_sel=1, offset at 1022, len=4 -> addresses 2046,2047,1024,1025 (wrap within region).
REQ-038 len=16 with m_ready toggling randomly/held low 10 cycles -> all 16 words in order, none lost or duplicated, stable data while stalled.
REQ-039 start_fetch while busy and len=0 request -> first ignored (no extra words); len=0 gives fetch_done one cycle later, zero bram_en.
REQ-040 rst asserted mid-fetch at word 3 of 8 -> all outputs 0 instantly; next fetch len=2 returns BRAM words 0,1; run with RD_LAT=1 and 2.
